// File: rtl/video_ser_tx_pkg.sv
// ============================================================================
// Module      : video_ser_tx_pkg
// Description : Shared FSM encodings and frame timing for the serial video TX.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package video_ser_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    localparam int c_frame_len = 16;
    localparam int c_latch_len = 2;

endpackage

`default_nettype wire

// File: rtl/video_ser_tx_sync_fall_edge.sv
// ============================================================================
// Module      : sync_fall_edge
// Description : Multi-stage synchronizer with registered falling-edge strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fall_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_fall;

    // History resets low so a line held low across reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_fall <= r_hist & ~r_sync[SYNC_STAGES-1];
        end
    end

    assign o_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/video_ser_tx.sv
// ============================================================================
// Module      : video_ser_tx
// Description : Captures RGB pixels at the 6 MHz rate and shifts them out on
//               three serial lanes with bit clock and latch strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module video_ser_tx
    import video_ser_tx_pkg::*;
#(
    parameter int DATA_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK_SERVID,
    input  logic              RESET,
    input  logic              CLK_6MB,
    input  logic              nBNKB,
    input  logic [DATA_W-1:0] VIDEO_R,
    input  logic [DATA_W-1:0] VIDEO_G,
    input  logic [DATA_W-1:0] VIDEO_B,
    input  logic              OVR_CLR,
    output logic              VIDEO_R_SER,
    output logic              VIDEO_G_SER,
    output logic              VIDEO_B_SER,
    output logic              VIDEO_CLK_SER,
    output logic              VIDEO_LAT_SER,
    output logic              OVERRUN
);

    localparam logic [2:0] c_last_bit   = 3'((c_frame_len - c_latch_len) / 2 - 1);
    localparam logic       c_latch_last = 1'(c_latch_len - 1);

    logic                  w_strobe;
    logic [3*DATA_W-1:0]   r_hold;
    logic                  r_pending;
    logic                  r_overrun;
    logic                  w_load;

    state_t                r_state, w_state_nxt;
    logic                  r_phase, w_phase_nxt;
    logic [2:0]            r_bitcnt, w_bitcnt_nxt;
    logic [DATA_W-1:0]     r_sh_r, r_sh_g, r_sh_b;
    logic [DATA_W-1:0]     w_sh_r_nxt, w_sh_g_nxt, w_sh_b_nxt;
    logic                  r_r_ser, r_g_ser, r_b_ser, r_clk_ser, r_lat_ser;
    logic                  w_r_ser_nxt, w_g_ser_nxt, w_b_ser_nxt;
    logic                  w_clk_ser_nxt, w_lat_ser_nxt, w_lane_en;

    sync_fall_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (CLK_SERVID),
        .rst     (RESET),
        .i_async (CLK_6MB),
        .o_fall  (w_strobe)
    );

    // A load in the same cycle as a strobe takes the old HOLD; the new pixel stays pending.
    always_ff @(posedge CLK_SERVID) begin
        if (RESET) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_strobe) begin
                r_hold    <= nBNKB ? {VIDEO_R, VIDEO_G, VIDEO_B} : '0;
                r_pending <= 1'b1;
            end else if (w_load) begin
                r_pending <= 1'b0;
            end
            if (w_strobe && r_pending && !w_load) begin
                r_overrun <= 1'b1;
            end else if (OVR_CLR) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_SERVID) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_phase   <= 1'b0;
            r_bitcnt  <= '0;
            r_sh_r    <= '0;
            r_sh_g    <= '0;
            r_sh_b    <= '0;
            r_r_ser   <= 1'b0;
            r_g_ser   <= 1'b0;
            r_b_ser   <= 1'b0;
            r_clk_ser <= 1'b0;
            r_lat_ser <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_sh_r    <= w_sh_r_nxt;
            r_sh_g    <= w_sh_g_nxt;
            r_sh_b    <= w_sh_b_nxt;
            r_r_ser   <= w_r_ser_nxt;
            r_g_ser   <= w_g_ser_nxt;
            r_b_ser   <= w_b_ser_nxt;
            r_clk_ser <= w_clk_ser_nxt;
            r_lat_ser <= w_lat_ser_nxt;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_bitcnt_nxt = r_bitcnt;
        w_sh_r_nxt   = r_sh_r;
        w_sh_g_nxt   = r_sh_g;
        w_sh_b_nxt   = r_sh_b;
        w_load       = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_load = 1'b1;
                end
            end
            SHIFT: begin
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    w_sh_r_nxt  = r_sh_r << 1;
                    w_sh_g_nxt  = r_sh_g << 1;
                    w_sh_b_nxt  = r_sh_b << 1;
                    if (r_bitcnt == c_last_bit) begin
                        w_state_nxt  = LATCH;
                        w_bitcnt_nxt = '0;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            LATCH: begin
                if (r_phase == c_latch_last) begin
                    w_phase_nxt = 1'b0;
                    if (r_pending) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_phase_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_load) begin
            w_state_nxt  = SHIFT;
            w_phase_nxt  = 1'b0;
            w_bitcnt_nxt = '0;
            w_sh_r_nxt   = r_hold[3*DATA_W-1:2*DATA_W];
            w_sh_g_nxt   = r_hold[2*DATA_W-1:DATA_W];
            w_sh_b_nxt   = r_hold[DATA_W-1:0];
        end

        w_lane_en     = (w_state_nxt == SHIFT);
        w_r_ser_nxt   = w_lane_en & w_sh_r_nxt[DATA_W-1];
        w_g_ser_nxt   = w_lane_en & w_sh_g_nxt[DATA_W-1];
        w_b_ser_nxt   = w_lane_en & w_sh_b_nxt[DATA_W-1];
        w_clk_ser_nxt = w_lane_en & w_phase_nxt;
        w_lat_ser_nxt = (w_state_nxt == LATCH);
    end

    assign VIDEO_R_SER   = r_r_ser;
    assign VIDEO_G_SER   = r_g_ser;
    assign VIDEO_B_SER   = r_b_ser;
    assign VIDEO_CLK_SER = r_clk_ser;
    assign VIDEO_LAT_SER = r_lat_ser;
    assign OVERRUN       = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_video_ser_tx.sv
// ============================================================================
// Module      : tb_video_ser_tx
// Description : Directed self-checking bench for the serial video transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_video_ser_tx;

    localparam int DATA_W      = 7;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_clk = 1'b0;
    logic              blank_n = 1'b1;
    logic [DATA_W-1:0] vid_r = '0;
    logic [DATA_W-1:0] vid_g = '0;
    logic [DATA_W-1:0] vid_b = '0;
    logic              ovr_clr = 1'b0;
    logic              r_ser, g_ser, b_ser, clk_ser, lat_ser, overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    video_ser_tx #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK_SERVID    (clk),
        .RESET         (rst),
        .CLK_6MB       (pix_clk),
        .nBNKB         (blank_n),
        .VIDEO_R       (vid_r),
        .VIDEO_G       (vid_g),
        .VIDEO_B       (vid_b),
        .OVR_CLR       (ovr_clr),
        .VIDEO_R_SER   (r_ser),
        .VIDEO_G_SER   (g_ser),
        .VIDEO_B_SER   (b_ser),
        .VIDEO_CLK_SER (clk_ser),
        .VIDEO_LAT_SER (lat_ser),
        .OVERRUN       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: lanes captured on bit-clock rises, one record per latch pulse.
    logic              m_prev_clk = 1'b0;
    logic              m_prev_lat = 1'b0;
    logic [DATA_W-1:0] m_r = '0, m_g = '0, m_b = '0;
    int                m_bits = 0, m_rises = 0, m_latlen = 0;
    logic [DATA_W-1:0] f_r[$], f_g[$], f_b[$];
    int                f_bits[$], f_rise[$], f_latlen[$];

    always @(negedge clk) begin
        if (clk_ser === 1'b1 && !m_prev_clk) begin
            m_r = {m_r[DATA_W-2:0], r_ser};
            m_g = {m_g[DATA_W-2:0], g_ser};
            m_b = {m_b[DATA_W-2:0], b_ser};
            m_bits++;
            m_rises++;
        end
        if (lat_ser === 1'b1 && !m_prev_lat) begin
            f_r.push_back(m_r);
            f_g.push_back(m_g);
            f_b.push_back(m_b);
            f_bits.push_back(m_bits);
            f_rise.push_back(cyc);
            m_bits   = 0;
            m_latlen = 0;
        end
        if (lat_ser === 1'b1) m_latlen++;
        if (lat_ser !== 1'b1 && m_prev_lat) f_latlen.push_back(m_latlen);
        m_prev_clk = (clk_ser === 1'b1);
        m_prev_lat = (lat_ser === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix_cycle(input int period);
        pix_clk = 1'b1;
        repeat (period / 2) tick();
        pix_clk = 1'b0;
        repeat (period - period / 2) tick();
    endtask

    task automatic clear_mon();
        f_r.delete(); f_g.delete(); f_b.delete();
        f_bits.delete(); f_rise.delete(); f_latlen.delete();
        m_bits = 0; m_rises = 0; m_latlen = 0;
        m_r = '0; m_g = '0; m_b = '0;
    endtask

    task automatic do_reset();
        pix_clk = 1'b0;
        ovr_clr = 1'b0;
        rst     = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({r_ser, g_ser, b_ser, clk_ser, lat_ser, overrun} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {r_ser, g_ser, b_ser, clk_ser, lat_ser, overrun});
        end
        rst = 1'b0;
        clear_mon();
        repeat (20) tick();
        n_checks++;
        if (m_rises != 0 || f_r.size() != 0) begin
            n_errors++;
            $display("FAIL reset_idle_quiet: got %0d clk rises %0d latches expected 0 0",
                     m_rises, f_r.size());
        end
    endtask

    task automatic test_frames(input string name, input logic bn);
        logic [DATA_W-1:0] exp_r, exp_g, exp_b;
        do_reset();
        vid_r = 7'h55; vid_g = 7'h2A; vid_b = 7'h7F; blank_n = bn;
        exp_r = bn ? 7'h55 : 7'h00;
        exp_g = bn ? 7'h2A : 7'h00;
        exp_b = bn ? 7'h7F : 7'h00;
        clear_mon();
        repeat (6) pix_cycle(16);
        repeat (30) tick();
        n_checks++;
        if (f_r.size() != 6 || f_latlen.size() != 6) begin
            n_errors++;
            $display("FAIL %s_frame_count: got %0d/%0d expected 6/6", name, f_r.size(), f_latlen.size());
        end
        for (int i = 0; i < f_r.size() && i < 6; i++) begin
            n_checks++;
            if ({f_r[i], f_g[i], f_b[i]} !== {exp_r, exp_g, exp_b} || f_bits[i] != DATA_W) begin
                n_errors++;
                $display("FAIL %s_frame%0d_data: got r=%h g=%h b=%h bits=%0d expected r=%h g=%h b=%h bits=7",
                         name, i, f_r[i], f_g[i], f_b[i], f_bits[i], exp_r, exp_g, exp_b);
            end
            if (i > 0) begin
                n_checks++;
                if (f_rise[i] - f_rise[i-1] != 16) begin
                    n_errors++;
                    $display("FAIL %s_frame%0d_spacing: got %0d expected 16", name, i,
                             f_rise[i] - f_rise[i-1]);
                end
            end
        end
        for (int i = 0; i < f_latlen.size(); i++) begin
            n_checks++;
            if (f_latlen[i] != 2) begin
                n_errors++;
                $display("FAIL %s_lat%0d_len: got %0d expected 2", name, i, f_latlen[i]);
            end
        end
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_no_overrun: got %b expected 0", name, overrun);
        end
    endtask

    task automatic test_latency();
        int first_data, first_clk, first_lat, lat_cycles;
        do_reset();
        vid_r = 7'h40; vid_g = 7'h00; vid_b = 7'h7F; blank_n = 1'b1;
        pix_clk = 1'b1;
        repeat (6) tick();
        pix_clk = 1'b0;
        first_data = -1; first_clk = -1; first_lat = -1; lat_cycles = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (first_data < 0 && r_ser === 1'b1) first_data = k;
            if (first_clk < 0 && clk_ser === 1'b1) first_clk = k;
            if (first_lat < 0 && lat_ser === 1'b1) first_lat = k;
            if (lat_ser === 1'b1) lat_cycles++;
        end
        n_checks++;
        if (first_data != SYNC_STAGES + 3) begin
            n_errors++;
            $display("FAIL latency_first_data: got %0d expected %0d", first_data, SYNC_STAGES + 3);
        end
        n_checks++;
        if (first_clk != SYNC_STAGES + 4) begin
            n_errors++;
            $display("FAIL latency_first_clk: got %0d expected %0d", first_clk, SYNC_STAGES + 4);
        end
        n_checks++;
        if (first_lat != SYNC_STAGES + 17) begin
            n_errors++;
            $display("FAIL latency_lat: got %0d expected %0d", first_lat, SYNC_STAGES + 17);
        end
        n_checks++;
        if (lat_cycles != 2) begin
            n_errors++;
            $display("FAIL latency_lat_len: got %0d expected 2", lat_cycles);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        vid_r = 7'h11; vid_g = 7'h22; vid_b = 7'h33; blank_n = 1'b1;
        repeat (4) pix_cycle(12);
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_before: got %b expected 0", overrun);
        end
        pix_clk = 1'b1;
        repeat (6) tick();
        pix_clk = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_early: got %b expected 0", overrun);
        end
        tick();
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_set: got %b expected 1", overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_clear: got %b expected 0", overrun);
        end
        tick();
        repeat (3) pix_cycle(12);
        pix_clk = 1'b1;
        repeat (6) tick();
        pix_clk = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ovr_cleared_stays: got %b expected 0", overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_set_beats_clear: got %b expected 1", overrun);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        vid_r = 7'h55; vid_g = 7'h2A; vid_b = 7'h7F; blank_n = 1'b1;
        pix_clk = 1'b1;
        repeat (8) tick();
        pix_clk = 1'b0;
        repeat (11) tick();
        n_checks++;
        if ({r_ser, g_ser, b_ser, clk_ser} !== 4'b0110) begin
            n_errors++;
            $display("FAIL abort_bit3_lanes: got %b expected 0110", {r_ser, g_ser, b_ser, clk_ser});
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({r_ser, g_ser, b_ser, clk_ser, lat_ser, overrun} !== 6'b0) begin
            n_errors++;
            $display("FAIL abort_outputs: got %b expected 000000",
                     {r_ser, g_ser, b_ser, clk_ser, lat_ser, overrun});
        end
        rst = 1'b0;
        clear_mon();
        vid_r = 7'h33; vid_g = 7'h4C; vid_b = 7'h01;
        repeat (2) tick();
        pix_cycle(16);
        repeat (30) tick();
        n_checks++;
        if (f_r.size() != 1) begin
            n_errors++;
            $display("FAIL abort_next_count: got %0d expected 1", f_r.size());
        end else begin
            n_checks++;
            if ({f_r[0], f_g[0], f_b[0]} !== {7'h33, 7'h4C, 7'h01} || f_bits[0] != DATA_W) begin
                n_errors++;
                $display("FAIL abort_next_data: got r=%h g=%h b=%h bits=%0d expected r=33 g=4c b=01 bits=7",
                         f_r[0], f_g[0], f_b[0], f_bits[0]);
            end
        end
    endtask

    task automatic test_hold_low();
        pix_clk = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        pix_clk = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        clear_mon();
        repeat (40) tick();
        n_checks++;
        if (m_rises != 0 || f_r.size() != 0) begin
            n_errors++;
            $display("FAIL hold_low_no_frame: got %0d clk rises %0d latches expected 0 0",
                     m_rises, f_r.size());
        end
    endtask

    initial begin
        test_reset();
        test_frames("colour", 1'b1);
        test_frames("blank", 1'b0);
        test_latency();
        test_overrun();
        test_reset_abort();
        test_hold_low();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
